serial_frame_tx: RTL and testbench

//  Serial frame transmitter: the sending end of the start-nibble serial link.

---
 rtl/serial_frame_pkg.sv | 17 +
 rtl/serial_frame_tx_if.sv | 28 ++
 rtl/serial_frame_tx_bit_tick_gen.sv | 27 ++
 rtl/serial_frame_tx.sv | 127 ++++++++++++
 tb/tb_serial_frame_tx.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/serial_frame_pkg.sv
// Shared definitions for the start-nibble serial link.
// The transmitter and the start-detect receiver both import this package.
package serial_frame_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_BIT = 1'b0;
  localparam logic STOP_BIT  = 1'b1;
  localparam int   START_LEN = 4;

endpackage

// File: rtl/serial_frame_tx_if.sv
// Parallel-side handshake and serial-side line for the frame transmitter.
interface serial_frame_tx_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] data_in;
  logic              valid;
  logic              ready;
  logic              sOut;
  logic              busy;

  modport master (
    output data_in,
    output valid,
    input  ready,
    input  sOut,
    input  busy
  );

  modport slave (
    input  data_in,
    input  valid,
    output ready,
    output sOut,
    output busy
  );

endinterface

// File: rtl/serial_frame_tx_bit_tick_gen.sv
// Bit-time divider: while enabled, pulses tick on the last clk of every bit.
module bit_tick_gen #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic tick
);

  localparam int TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(CLKS_PER_BIT - 1);

  logic [TICK_W-1:0] tick_cnt;

  assign tick = en && (tick_cnt == LAST_TICK);

  // Held at zero while disabled so the first bit of a frame gets full length
  always_ff @(posedge clk) begin
    if (!rst || !en || tick) begin
      tick_cnt <= '0;
    end else begin
      tick_cnt <= tick_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/serial_frame_tx.sv
// Serial frame transmitter: start nibble of zeros, LSB-first payload, stop ones.
// Back-to-back frames are accepted in the last cycle of the previous stop bit.
module serial_frame_tx #(
  parameter int DATA_W       = 8,
  parameter int START_LEN    = serial_frame_pkg::START_LEN,
  parameter int STOP_LEN     = 2,
  parameter int CLKS_PER_BIT = 1
) (
  input logic              clk,
  input logic              rst,
  serial_frame_tx_if.slave tx
);

  import serial_frame_pkg::*;

  localparam int MAX_LEN_A = (START_LEN > DATA_W) ? START_LEN : DATA_W;
  localparam int MAX_LEN   = (MAX_LEN_A > STOP_LEN) ? MAX_LEN_A : STOP_LEN;
  localparam int BIT_W     = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

  localparam logic [BIT_W-1:0] START_LAST = BIT_W'(START_LEN - 1);
  localparam logic [BIT_W-1:0] DATA_LAST  = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] STOP_LAST  = BIT_W'(STOP_LEN - 1);

  tx_state_t         state, state_n;
  logic [BIT_W-1:0]  bit_cnt, bit_n;
  logic [DATA_W-1:0] shreg, sh_n;
  logic              sout_q, sout_n;
  logic              ready_c;
  logic              tick;

  bit_tick_gen #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk (clk),
    .rst (rst),
    .en  (state != IDLE),
    .tick(tick)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      bit_cnt <= '0;
      shreg   <= '0;
      sout_q  <= LINE_IDLE;
    end else begin
      state   <= state_n;
      bit_cnt <= bit_n;
      shreg   <= sh_n;
      sout_q  <= sout_n;
    end
  end

  // sOut is registered from the next state so the line changes with the state
  always_comb begin
    state_n = state;
    bit_n   = bit_cnt;
    sh_n    = shreg;
    ready_c = 1'b0;
    sout_n  = LINE_IDLE;

    case (state)
      IDLE: begin
        ready_c = 1'b1;
        if (tx.valid) begin
          state_n = START;
          bit_n   = '0;
          sh_n    = tx.data_in;
        end
      end
      START: begin
        if (tick) begin
          if (bit_cnt == START_LAST) begin
            state_n = DATA;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          sh_n = shreg >> 1;
          if (bit_cnt == DATA_LAST) begin
            state_n = STOP;
            bit_n   = '0;
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      STOP: begin
        if (tick) begin
          if (bit_cnt == STOP_LAST) begin
            ready_c = 1'b1;
            bit_n   = '0;
            if (tx.valid) begin
              state_n = START;
              sh_n    = tx.data_in;
            end else begin
              state_n = IDLE;
            end
          end else begin
            bit_n = bit_cnt + 1'b1;
          end
        end
      end
      default: begin
        state_n = IDLE;
        bit_n   = '0;
      end
    endcase

    case (state_n)
      IDLE:    sout_n = LINE_IDLE;
      START:   sout_n = START_BIT;
      DATA:    sout_n = sh_n[0];
      STOP:    sout_n = STOP_BIT;
      default: sout_n = LINE_IDLE;
    endcase
  end

  assign tx.ready = ready_c;
  assign tx.sOut  = sout_q;
  assign tx.busy  = (state != IDLE);

endmodule

// File: tb/tb_serial_frame_tx.sv
// Drives a 1-clk-per-bit and a 3-clk-per-bit transmitter with the same stimulus
// and compares both against a per-cycle queue of expected line levels.
module tb_serial_frame_tx;

  localparam int DATA_W    = 8;
  localparam int START_LEN = 4;
  localparam int STOP_LEN  = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  serial_frame_tx_if #(.DATA_W(DATA_W)) bus1 ();
  serial_frame_tx_if #(.DATA_W(DATA_W)) bus3 ();

  serial_frame_tx #(
    .DATA_W(DATA_W), .START_LEN(START_LEN), .STOP_LEN(STOP_LEN), .CLKS_PER_BIT(1)
  ) dut1 (
    .clk(clk), .rst(rst), .tx(bus1)
  );

  serial_frame_tx #(
    .DATA_W(DATA_W), .START_LEN(START_LEN), .STOP_LEN(STOP_LEN), .CLKS_PER_BIT(3)
  ) dut3 (
    .clk(clk), .rst(rst), .tx(bus3)
  );

  int   errors = 0;
  int   checks = 0;
  int   busy1Cnt = 0;
  int   busy3Cnt = 0;
  logic q1[$];
  logic q3[$];

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected line levels of one whole frame, one entry per clk
  task automatic pushFrame(input int cpb, input logic [DATA_W-1:0] d, input bit third);
    logic bits[$];
    for (int i = 0; i < START_LEN; i++) bits.push_back(1'b0);
    for (int i = 0; i < DATA_W; i++) bits.push_back(d[i]);
    for (int i = 0; i < STOP_LEN; i++) bits.push_back(1'b1);
    foreach (bits[i]) begin
      repeat (cpb) begin
        if (third) q3.push_back(bits[i]);
        else q1.push_back(bits[i]);
      end
    end
  endtask

  // One clock cycle: drive, advance the model at the edge, then check both DUTs
  task automatic applyStimulus(input logic r, input logic v, input logic [DATA_W-1:0] d);
    logic rdy1, rdy3;
    rst          = r;
    bus1.valid   = v;
    bus3.valid   = v;
    bus1.data_in = d;
    bus3.data_in = d;
    rdy1 = (q1.size() <= 1);
    rdy3 = (q3.size() <= 1);
    @(posedge clk);
    if (!r) begin
      q1.delete();
      q3.delete();
    end else begin
      if (q1.size() > 0) void'(q1.pop_front());
      if (q3.size() > 0) void'(q3.pop_front());
      if (v && rdy1) pushFrame(1, d, 1'b0);
      if (v && rdy3) pushFrame(3, d, 1'b1);
    end
    #1;
    checkOutput("sOut1",  bus1.sOut,  (q1.size() > 0) ? q1[0] : 1'b1);
    checkOutput("busy1",  bus1.busy,  (q1.size() > 0));
    checkOutput("ready1", bus1.ready, (q1.size() <= 1));
    checkOutput("sOut3",  bus3.sOut,  (q3.size() > 0) ? q3[0] : 1'b1);
    checkOutput("busy3",  bus3.busy,  (q3.size() > 0));
    checkOutput("ready3", bus3.ready, (q3.size() <= 1));
    if (bus1.busy === 1'b1) busy1Cnt++;
    if (bus3.busy === 1'b1) busy3Cnt++;
  endtask

  task automatic waitIdle(input int limit);
    for (int i = 0; i < limit && (q1.size() > 0 || q3.size() > 0); i++) begin
      applyStimulus(1'b1, 1'b0, DATA_W'($urandom));
    end
    checkOutput("idle1", bus1.busy, 1'b0);
    checkOutput("idle3", bus3.busy, 1'b0);
  endtask

  initial begin
    logic expA5 [15];
    expA5 = '{0,0,0,0, 1,0,1,0,0,1,0,1, 1,1, 1};

    // Reset held with valid high must not start a frame
    applyStimulus(1'b0, 1'b1, 8'h5A);
    applyStimulus(1'b0, 1'b1, 8'h5A);
    checkOutput("rst_sOut",  bus1.sOut,  1'b1);
    checkOutput("rst_ready", bus1.ready, 1'b1);
    checkOutput("rst_busy",  bus1.busy,  1'b0);

    // Single 0xA5 frame, cycle-exact line pattern
    applyStimulus(1'b1, 1'b1, 8'hA5);
    for (int i = 0; i < 15; i++) begin
      if (i > 0) applyStimulus(1'b1, 1'b0, 8'h00);
      checkOutput("a5_line",  bus1.sOut,  expA5[i]);
      checkOutput("a5_ready", bus1.ready, (i >= 13));
      checkOutput("a5_busy",  bus1.busy,  (i < 14));
    end
    waitIdle(100);

    // Back-to-back 0x00 then 0xFF with valid held
    busy1Cnt = 0;
    busy3Cnt = 0;
    applyStimulus(1'b1, 1'b1, 8'h00);
    for (int i = 0; i < 14; i++) applyStimulus(1'b1, 1'b1, 8'hFF);
    waitIdle(200);
    checkOutput("b2b_busy1", busy1Cnt, 28);
    checkOutput("frame_busy3", busy3Cnt, 42);

    // Data bit 0 of 0x01 held for three clocks on the slow transmitter
    applyStimulus(1'b1, 1'b1, 8'h01);
    for (int c = 2; c <= 16; c++) begin
      applyStimulus(1'b1, 1'b0, 8'h00);
      if (c >= 12) checkOutput("cpb3_bit0", bus3.sOut, (c >= 13 && c <= 15));
    end
    waitIdle(100);

    // Input changes and valid pulses mid-frame are ignored
    applyStimulus(1'b1, 1'b1, 8'h3C);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 1'b0, 8'hFF);
    checkOutput("mid_ready", bus1.ready, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'hFF);
    waitIdle(100);

    // Reset during data bit 3 abandons the frame, then 0x81 goes out
    applyStimulus(1'b1, 1'b1, 8'hC3);
    for (int i = 0; i < 7; i++) applyStimulus(1'b1, 1'b0, 8'h00);
    applyStimulus(1'b0, 1'b0, 8'h00);
    checkOutput("abort_sOut",  bus1.sOut,  1'b1);
    checkOutput("abort_busy",  bus1.busy,  1'b0);
    checkOutput("abort_ready", bus1.ready, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'h81);
    waitIdle(100);

    // Random traffic with occasional resets
    for (int i = 0; i < 600; i++) begin
      applyStimulus(($urandom_range(0, 63) != 0), ($urandom_range(0, 2) != 0), DATA_W'($urandom));
    end
    waitIdle(200);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
